// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/result-select encodings, immediate kinds.
// Pure constants plus one combinational helper, so it has no latency.
// No flow control; the package only holds types and functions.
package riscv_pkg;

  // Major opcodes decoded by the main decoder
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALU operation encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Writeback result source select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_src_t;

  // Sign-extend the immediate of the given format; B/J have an implicit zero LSB.
  function automatic logic [31:0] extend_imm(input logic [31:0] instr, input imm_src_t src);
    logic [31:0] imm;
    imm = '0;
    case (src)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/register_file.sv
// Register file: 2 combinational read ports, 1 write port at the rising edge, x0 hardwired to 0.
// Reads are zero-latency; writes land at the edge. Define RF_WRITE_FIRST_EN for write-through bypass.
// No backpressure; a write is accepted every cycle it is requested.
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_live;

  assign wr_live = we && (wa != 5'd0);

  // Storage: cleared asynchronously on reset, writes to x0 dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wa] <= wd;
    end
  end

  // Read ports: x0 always zero, optional same-cycle bypass of the pending write
  always_comb begin
    rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
`ifdef RF_WRITE_FIRST_EN
    if (wr_live && (wa == ra1)) rd1 = wd;
    if (wr_live && (wa == ra2)) rd2 = wd;
`endif
  end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: control decode, immediate extend, register read, ID/EX pipeline register.
// E outputs are valid 1 cycle after InstrD; Rs1D/Rs2D are combinational. Build option: RF_WRITE_FIRST_EN.
// No stall input; FlushE or an empty slot loads a bubble into ID/EX.
module instruction_decode
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            validD,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            validE
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd_idx;
  logic            reg_write, mem_write, jump, branch, alu_src;
  logic [1:0]      result_src;
  logic [2:0]      alu_control;
  imm_src_t        imm_src;
  logic [XLEN-1:0] rd1, rd2;
  logic            load_bubble;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rd_idx = InstrD[11:7];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  assign load_bubble = FlushE || !validD;

  register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (Rs1D),
    .ra2 (Rs2D),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW)
  );

  // Main and ALU decoders; unknown opcodes decode to an all-zero bubble
  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    alu_src     = 1'b0;
    result_src  = RES_ALU;
    alu_control = ALU_ADD;
    imm_src     = IMM_NONE;
    case (opcode)
      OP_LW:  begin reg_write = 1'b1; alu_src = 1'b1; result_src = RES_MEM; imm_src = IMM_I; end
      OP_SW:  begin mem_write = 1'b1; alu_src = 1'b1; imm_src = IMM_S; end
      OP_R:   reg_write = 1'b1;
      OP_I:   begin reg_write = 1'b1; alu_src = 1'b1; imm_src = IMM_I; end
      OP_BEQ: begin branch = 1'b1; alu_control = ALU_SUB; imm_src = IMM_B; end
      OP_JAL: begin reg_write = 1'b1; jump = 1'b1; result_src = RES_PC4; imm_src = IMM_J; end
      default: ;
    endcase
    if (opcode == OP_R || opcode == OP_I) begin
      case (funct3)
        3'b000:  alu_control = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
        3'b010:  alu_control = ALU_SLT;
        3'b110:  alu_control = ALU_OR;
        3'b111:  alu_control = ALU_AND;
        default: alu_control = ALU_ADD;
      endcase
    end
  end

  // ID/EX register: data always loads, controls and indices zeroed on a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      validE      <= 1'b0;
    end else begin
      RD1E     <= rd1;
      RD2E     <= rd2;
      ImmExtE  <= extend_imm(InstrD, imm_src);
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      if (load_bubble) begin
        RegWriteE   <= 1'b0;
        MemWriteE   <= 1'b0;
        JumpE       <= 1'b0;
        BranchE     <= 1'b0;
        ALUSrcE     <= 1'b0;
        ResultSrcE  <= '0;
        ALUControlE <= '0;
        Rs1E        <= '0;
        Rs2E        <= '0;
        RdE         <= '0;
        validE      <= 1'b0;
      end else begin
        RegWriteE   <= reg_write;
        MemWriteE   <= mem_write;
        JumpE       <= jump;
        BranchE     <= branch;
        ALUSrcE     <= alu_src;
        ResultSrcE  <= result_src;
        ALUControlE <= alu_control;
        Rs1E        <= Rs1D;
        Rs2E        <= Rs2D;
        RdE         <= rd_idx;
        validE      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode with hand-computed expected values.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Same-cycle W->D expectation follows RF_WRITE_FIRST_EN.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        validD, FlushE, RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [4:0]  Rs1D, Rs2D;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        validE;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] I_ADD_X7_X5 = 32'h000283B3;
  localparam logic [31:0] I_ADD_X7_X3 = 32'h000183B3;
  localparam logic [31:0] I_ADD_RS2X3 = 32'h003003B3;
  localparam logic [31:0] I_ADD_X0    = 32'h000003B3;
  localparam logic [31:0] I_SW        = 32'hFE20AE23;
  localparam logic [31:0] I_BEQ       = 32'h00208463;
  localparam logic [31:0] I_LW        = 32'h0082A303;
  localparam logic [31:0] I_SUB       = 32'h403100B3;
  localparam logic [31:0] I_SLT       = 32'h003120B3;
  localparam logic [31:0] I_ADDI_NEG  = 32'hC0010093;
  localparam logic [31:0] I_ORI       = 32'h00516093;
  localparam logic [31:0] I_ANDI      = 32'h00517093;
  localparam logic [31:0] I_JAL       = 32'hFFDFF0EF;

  instruction_decode dut (
    .clk(clk), .rst(rst),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .validD(validD), .FlushE(FlushE),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .validE(validE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] val);
    RegWriteW = en;
    RdW       = rd;
    ResultW   = val;
  endtask

  initial begin
    rst = 1'b1;
    InstrD = I_ADD_X7_X5; PCD = 32'h100; PCPlus4D = 32'h104;
    validD = 1'b1; FlushE = 1'b0;
    wb(1'b0, 5'd0, 32'h0);

    // Held in reset: all E outputs zero
    tick(); tick();
    check("rst_validE", {31'b0, validE}, 32'd0);
    check("rst_RegWriteE", {31'b0, RegWriteE}, 32'd0);
    check("rst_PCE", PCE, 32'd0);
    check("rst_RdE", {27'b0, RdE}, 32'd0);

    // Write x5, then read it back
    rst = 1'b0;
    wb(1'b1, 5'd5, 32'h0000CAFE);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check("pre_rst_RD1E", RD1E, 32'h0000CAFE);
    check("pre_rst_validE", {31'b0, validE}, 32'd1);

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    #3 rst = 1'b1;
    #1;
    check("async_rst_validE", {31'b0, validE}, 32'd0);
    check("async_rst_RD1E", RD1E, 32'd0);
    check("async_rst_PCE", PCE, 32'd0);
    #1 rst = 1'b0;
    tick();
    check("x5_cleared", RD1E, 32'd0);

    // Write x5 = DEADBEEF while an all-zero instruction decodes as a bubble
    InstrD = 32'h0;
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check("zero_RegWriteE", {31'b0, RegWriteE}, 32'd0);
    check("zero_MemWriteE", {31'b0, MemWriteE}, 32'd0);
    check("zero_BranchE", {31'b0, BranchE}, 32'd0);
    check("zero_ALUSrcE", {31'b0, ALUSrcE}, 32'd0);
    check("zero_ImmExtE", ImmExtE, 32'd0);

    // add x7,x5,x0
    wb(1'b0, 5'd0, 32'h0);
    InstrD = I_ADD_X7_X5; PCD = 32'h200; PCPlus4D = 32'h204;
    tick();
    check("add_RD1E", RD1E, 32'hDEADBEEF);
    check("add_RegWriteE", {31'b0, RegWriteE}, 32'd1);
    check("add_ALUControlE", {29'b0, ALUControlE}, 32'd0);
    check("add_RdE", {27'b0, RdE}, 32'd7);
    check("add_validE", {31'b0, validE}, 32'd1);
    check("add_PCE", PCE, 32'h200);
    check("add_PCPlus4E", PCPlus4E, 32'h204);

    // sw x2,-4(x1), plus combinational source indices
    InstrD = I_SW;
    #1;
    check("sw_Rs1D", {27'b0, Rs1D}, 32'd1);
    check("sw_Rs2D", {27'b0, Rs2D}, 32'd2);
    tick();
    check("sw_ImmExtE", ImmExtE, 32'hFFFFFFFC);
    check("sw_MemWriteE", {31'b0, MemWriteE}, 32'd1);
    check("sw_RegWriteE", {31'b0, RegWriteE}, 32'd0);
    check("sw_ALUSrcE", {31'b0, ALUSrcE}, 32'd1);
    check("sw_Rs2E", {27'b0, Rs2E}, 32'd2);

    // beq flushed, then not flushed
    InstrD = I_BEQ; FlushE = 1'b1;
    tick();
    check("beqf_BranchE", {31'b0, BranchE}, 32'd0);
    check("beqf_validE", {31'b0, validE}, 32'd0);
    check("beqf_RegWriteE", {31'b0, RegWriteE}, 32'd0);
    check("beqf_Rs1E", {27'b0, Rs1E}, 32'd0);
    FlushE = 1'b0;
    tick();
    check("beq_BranchE", {31'b0, BranchE}, 32'd1);
    check("beq_ImmExtE", ImmExtE, 32'd8);
    check("beq_ALUControlE", {29'b0, ALUControlE}, 32'd1);
    check("beq_validE", {31'b0, validE}, 32'd1);

    // Empty slot bubbles a lw; flush plus empty slot also bubbles
    InstrD = I_LW; validD = 1'b0;
    tick();
    check("novalid_validE", {31'b0, validE}, 32'd0);
    check("novalid_RegWriteE", {31'b0, RegWriteE}, 32'd0);
    FlushE = 1'b1;
    tick();
    check("both_validE", {31'b0, validE}, 32'd0);
    check("both_RdE", {27'b0, RdE}, 32'd0);
    FlushE = 1'b0; validD = 1'b1;

    // lw x6,8(x5): funct3=010 must still use add
    tick();
    check("lw_ResultSrcE", {30'b0, ResultSrcE}, 32'd1);
    check("lw_ALUControlE", {29'b0, ALUControlE}, 32'd0);
    check("lw_ImmExtE", ImmExtE, 32'd8);
    check("lw_RD1E", RD1E, 32'hDEADBEEF);
    check("lw_ALUSrcE", {31'b0, ALUSrcE}, 32'd1);

    // ALU decoder patterns
    InstrD = I_SUB;      tick(); check("sub_ALUControlE", {29'b0, ALUControlE}, 32'b001);
    InstrD = I_SLT;      tick(); check("slt_ALUControlE", {29'b0, ALUControlE}, 32'b101);
    InstrD = I_ADDI_NEG; tick(); check("addi_ALUControlE", {29'b0, ALUControlE}, 32'b000);
    check("addi_ImmExtE", ImmExtE, 32'hFFFFFC00);
    InstrD = I_ORI;      tick(); check("ori_ALUControlE", {29'b0, ALUControlE}, 32'b011);
    InstrD = I_ANDI;     tick(); check("andi_ALUControlE", {29'b0, ALUControlE}, 32'b010);

    // jal x1,-4
    InstrD = I_JAL;
    tick();
    check("jal_ImmExtE", ImmExtE, 32'hFFFFFFFC);
    check("jal_JumpE", {31'b0, JumpE}, 32'd1);
    check("jal_ResultSrcE", {30'b0, ResultSrcE}, 32'd2);
    check("jal_RegWriteE", {31'b0, RegWriteE}, 32'd1);

    // Unknown opcode with all other bits set is a bubble
    InstrD = 32'hFFFFFFFF;
    tick();
    check("unk_RegWriteE", {31'b0, RegWriteE}, 32'd0);
    check("unk_JumpE", {31'b0, JumpE}, 32'd0);
    check("unk_ImmExtE", ImmExtE, 32'd0);

    // Write to x0 is ignored, both same-cycle and afterwards
    InstrD = I_ADD_X0;
    wb(1'b1, 5'd0, 32'h1234);
    tick();
    check("x0_same_RD1E", RD1E, 32'd0);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check("x0_later_RD1E", RD1E, 32'd0);

    // Same-cycle W->D on x3
    InstrD = 32'h0;
    wb(1'b1, 5'd3, 32'h11);
    tick();
    InstrD = I_ADD_X7_X3;
    wb(1'b1, 5'd3, 32'h55);
    tick();
`ifdef RF_WRITE_FIRST_EN
    check("wfirst_RD1E", RD1E, 32'h55);
`else
    check("wfirst_RD1E", RD1E, 32'h11);
`endif
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check("x3_after_RD1E", RD1E, 32'h55);
    InstrD = I_ADD_RS2X3;
    tick();
    check("x3_rs2_RD2E", RD2E, 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Decode stage of the five-stage RV32I pipeline, directly downstream of instruction fetch. Consumes the IF/ID register outputs (`InstrD`, `PCD`, `PCPlus4D`, `validD`), decodes control, extends immediates, reads the 32×32 register file (written back from W), and registers everything into the ID/EX pipeline register. Source-register indices are also driven combinationally to the hazard unit.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `NREGS`, 32, register count (index width 5)

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: rising-edge clock
- `rst` in 1: async active-high reset
- `InstrD`, `PCD`, `PCPlus4D` in 32: from IF/ID register
- `validD` in 1: IF/ID slot holds a real instruction
- `FlushE` in 1: hazard unit, bubble the ID/EX register
- `RegWriteW` in 1, `RdW` in 5, `ResultW` in 32: writeback port
- `Rs1D`, `Rs2D` out 5: combinational `InstrD[19:15]`, `InstrD[24:20]` to hazard unit
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE` out 1: registered controls
- `ResultSrcE` out 2: 00 ALU, 01 memory, 10 PC+4
- `ALUControlE` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt
- `RD1E`, `RD2E`, `ImmExtE`, `PCE`, `PCPlus4E` out 32
- `Rs1E`, `Rs2E`, `RdE` out 5
- `validE` out 1

## Operation
- Main decoder by `InstrD[6:0]`:
  - `0000011` lw: RegWrite, ALUSrc, ResultSrc=01, I-imm
  - `0100011` sw: MemWrite, ALUSrc, S-imm
  - `0110011` R-type: RegWrite
  - `0010011` I-ALU: RegWrite, ALUSrc, I-imm
  - `1100011` beq: Branch, ALU sub, B-imm
  - `1101111` jal: RegWrite, Jump, ResultSrc=10, J-imm
  - Any other opcode, including all-zero: all controls 0 (bubble).
- ALU decoder (R/I-ALU) by funct3:
  - 000: add, or sub when R-type and `funct7[5]`=1
  - 010: slt
  - 110: or
  - 111: and
  - Other funct3 values: add.
  - lw/sw/jal use add.
- Immediates are sign-extended from `InstrD[31]`. B and J immediates have bit0 = 0. Non-immediate opcodes give `ImmExtE` = 0.
- Register file:
  - x0 reads 0 always; writes to x0 are ignored.
  - Write occurs at the rising edge when `RegWriteW` is high and `RdW` ≠ 0.
- ID/EX register loads every rising edge (no stall input).
  - `FlushE`=1 or `validD`=0: all controls, `validE`, and index fields load 0.
  - Otherwise: decoded values load, and `validE` = 1.
  - Both conditions true: flush wins (identical result).

## Timing
- Decode/read/extend are combinational in D; all E outputs appear 1 cycle after `InstrD` is presented.
- `Rs1D`/`Rs2D` are zero-latency.
- Reset: all E outputs 0, all registers x1–x31 cleared to 0, asynchronously on `rst` assertion, including mid-operation. First load occurs at the first rising edge after deassertion.
- A writeback and a read of the same register in the same cycle behave per the Configuration section. Every other read sees the value written at an earlier edge.

## Configuration
- `RF_WRITE_FIRST_EN` defined: write-through bypass. If `RegWriteW` is high, `RdW` ≠ 0, and `RdW` equals the read index, the read port returns `ResultW` in the same cycle. The hazard unit needs no extra W→D stall.
- `RF_WRITE_FIRST_EN` undefined: the read returns the pre-write value. The hazard unit must stall D one cycle on a W→D match.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants
  - `ALUControl` encodings
  - `ResultSrc` encodings
  - `ImmSrc` enum (I/S/B/J/none)
- Sub-module `register_file`: 2 read ports, 1 write port, async reset, bypass under the macro.
- Control and immediate logic stay inline.

## Test plan
- Reset: assert `rst` mid-stream → all E outputs 0; after release, reading x5 returns 0.
- Write x5=0xDEADBEEF via W. Next cycle `InstrD`=0x000283B3 (add x7,x5,x0) → after 1 cycle: `RD1E`=0xDEADBEEF, `RegWriteE`=1, `ALUControlE`=000, `RdE`=7, `validE`=1.
- `InstrD`=0xFE20AE23 (sw x2,-4(x1)) → `ImmExtE`=0xFFFFFFFC, `MemWriteE`=1, `RegWriteE`=0, `ALUSrcE`=1, `Rs2E`=2.
- `InstrD`=0x00208463 (beq x1,x2,+8) with `FlushE`=1 → `BranchE`=0, `validE`=0, `RegWriteE`=0. With `FlushE`=0 → `BranchE`=1, `ImmExtE`=8, `ALUControlE`=001.
- Write x0=0x1234, then read x0 → `RD1E`=0. `InstrD`=0 with `validD`=1 → bubble, all controls 0.
- Same-cycle W write x3=0x55 and read x3 (old value 0x11) → `RD1E`=0x55 with `RF_WRITE_FIRST_EN` defined, 0x11 without.
